// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the hazard controller: FSM states, scoreboard entry
// layout and the pipeline control bundle with its fixed patterns.
package hazard_ctrl_pkg;

  localparam int REG_W = 3;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             is_load;
  } sb_entry_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_pass;
    logic exmem_en;
    logic memwb_en;
  } ctrl_t;

  // Also used while draining/halted: front end flushed, back end keeps moving.
  localparam ctrl_t CTRL_RESET = '{pc_en: 1'b0, ifid_en: 1'b1, ifid_flush: 1'b1,
                                   idex_en: 1'b1, idex_pass: 1'b0,
                                   exmem_en: 1'b1, memwb_en: 1'b1};
  localparam ctrl_t CTRL_FREEZE = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
                                    idex_en: 1'b0, idex_pass: 1'b0,
                                    exmem_en: 1'b0, memwb_en: 1'b0};
  localparam ctrl_t CTRL_REDIRECT = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b1,
                                      idex_en: 1'b1, idex_pass: 1'b0,
                                      exmem_en: 1'b1, memwb_en: 1'b1};
  localparam ctrl_t CTRL_RAW = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
                                 idex_en: 1'b1, idex_pass: 1'b0,
                                 exmem_en: 1'b1, memwb_en: 1'b1};
  localparam ctrl_t CTRL_IFETCH = '{pc_en: 1'b0, ifid_en: 1'b1, ifid_flush: 1'b1,
                                    idex_en: 1'b1, idex_pass: 1'b1,
                                    exmem_en: 1'b1, memwb_en: 1'b1};
  localparam ctrl_t CTRL_RUN = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0,
                                 idex_en: 1'b1, idex_pass: 1'b1,
                                 exmem_en: 1'b1, memwb_en: 1'b1};

  // r0 is an ordinary register here, so no zero-register exclusion.
  function automatic logic src_match(input logic [REG_W-1:0] rs, input logic rs_used,
                                     input logic [REG_W-1:0] rt, input logic rt_used,
                                     input logic [REG_W-1:0] rd);
    return (rs_used & (rs == rd)) | (rt_used & (rt == rd));
  endfunction

endpackage

// File: rtl/hazard_ctrl_sb_entry.sv
// One scoreboard slot: holds the destination info of the instruction in one
// stage and reports whether the instruction in decode reads it.
module hazard_ctrl_sb_entry
  import hazard_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             adv_i,
  input  sb_entry_t        ent_d_i,
  input  logic [REG_W-1:0] rs_i,
  input  logic             rs_used_i,
  input  logic [REG_W-1:0] rt_i,
  input  logic             rt_used_i,
  output sb_entry_t        ent_o,
  output logic             match_o
);

  sb_entry_t ent_q;

  // Entry register; holds whenever the pipeline is frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q <= '0;
    end else if (adv_i) begin
      ent_q <= ent_d_i;
    end
  end

  assign ent_o   = ent_q;
  assign match_o = ent_q.valid & src_match(rs_i, rs_used_i, rt_i, rt_used_i, ent_q.rd);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: priority mux over data-memory stall,
// redirect, RAW stall and fetch stall, plus the halt drain FSM.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_RUN    | normal issue; halt entering EX moves to ST_DRAIN
// ST_DRAIN  | front end flushed, counting unstalled cycles until drained
// ST_HALTED | pipeline empty, Halted asserted until reset
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter bit FWD       = 1'b1,
  parameter bit WB_BYPASS = 1'b1,
  parameter int DRAIN_CYC = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] Rs_id,
  input  logic             RsUsed_id,
  input  logic [REG_W-1:0] Rt_id,
  input  logic             RtUsed_id,
  input  logic [REG_W-1:0] WrReg_id,
  input  logic             RegWrite_id,
  input  logic             MemtoReg_id,
  input  logic             Halt_id,
  input  logic             BrTaken_ex,
  input  logic             IMemStall,
  input  logic             DMemStall,
  output logic             PCEn,
  output logic             IfidEn,
  output logic             IfidFlush,
  output logic             IdexEn,
  output logic             IdexPass,
  output logic             ExmemEn,
  output logic             MemwbEn,
  output logic             Halted
);

  localparam int CNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYC - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ex_live_q, ex_live_d;

  sb_entry_t ex_ent, mem_ent, wb_ent, ex_d;
  logic      ex_match, mem_match, wb_match;
  logic      raw_hit, redirect, advance;
  ctrl_t     ctrl;
  logic      unused_wb_ent;

  assign advance  = ~DMemStall;
  assign redirect = BrTaken_ex & ex_live_q;

  // A squashed slot enters EX as invalid so it can never cause a stall.
  assign ex_d = '{valid: ctrl.idex_pass & RegWrite_id, rd: WrReg_id, is_load: MemtoReg_id};

  hazard_ctrl_sb_entry u_sb_ex (
    .clk       (clk),
    .rst       (rst),
    .adv_i     (advance),
    .ent_d_i   (ex_d),
    .rs_i      (Rs_id),
    .rs_used_i (RsUsed_id),
    .rt_i      (Rt_id),
    .rt_used_i (RtUsed_id),
    .ent_o     (ex_ent),
    .match_o   (ex_match)
  );

  hazard_ctrl_sb_entry u_sb_mem (
    .clk       (clk),
    .rst       (rst),
    .adv_i     (advance),
    .ent_d_i   (ex_ent),
    .rs_i      (Rs_id),
    .rs_used_i (RsUsed_id),
    .rt_i      (Rt_id),
    .rt_used_i (RtUsed_id),
    .ent_o     (mem_ent),
    .match_o   (mem_match)
  );

  hazard_ctrl_sb_entry u_sb_wb (
    .clk       (clk),
    .rst       (rst),
    .adv_i     (advance),
    .ent_d_i   (mem_ent),
    .rs_i      (Rs_id),
    .rs_used_i (RsUsed_id),
    .rt_i      (Rt_id),
    .rt_used_i (RtUsed_id),
    .ent_o     (wb_ent),
    .match_o   (wb_match)
  );

  // The WB slot is the end of the chain; only its match result is consumed.
  assign unused_wb_ent = ^wb_ent;

  // RAW detection: with forwarding only a load still in EX cannot be bypassed.
  always_comb begin
    raw_hit = 1'b0;
    if (FWD) begin
      raw_hit = ex_match & ex_ent.is_load;
    end else begin
      raw_hit = ex_match | mem_match | (~WB_BYPASS & wb_match);
    end
  end

  // Priority mux for all pipeline enables.
  always_comb begin
    ctrl = CTRL_RUN;
    if (rst) begin
      ctrl = CTRL_RESET;
    end else if (DMemStall) begin
      ctrl = CTRL_FREEZE;
    end else if (state_q != ST_RUN) begin
      ctrl = CTRL_RESET;
    end else if (redirect) begin
      ctrl = CTRL_REDIRECT;
    end else if (raw_hit) begin
      ctrl = CTRL_RAW;
    end else if (IMemStall) begin
      ctrl = CTRL_IFETCH;
    end
  end

  assign PCEn      = ctrl.pc_en;
  assign IfidEn    = ctrl.ifid_en;
  assign IfidFlush = ctrl.ifid_flush;
  assign IdexEn    = ctrl.idex_en;
  assign IdexPass  = ctrl.idex_pass;
  assign ExmemEn   = ctrl.exmem_en;
  assign MemwbEn   = ctrl.memwb_en;
  assign Halted    = ~rst & (state_q == ST_HALTED);

  // Halt/drain next state; only unstalled cycles count towards the drain.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ex_live_d = ctrl.idex_pass;
    unique case (state_q)
      ST_RUN: begin
        if (ctrl.idex_pass & Halt_id) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_HALTED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // State register; frozen along with the pipeline during a data-memory stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      ex_live_q <= 1'b0;
    end else if (advance) begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ex_live_q <= ex_live_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  // Output vector order: {PCEn, IfidEn, IfidFlush, IdexEn, IdexPass, ExmemEn, MemwbEn, Halted}
  localparam logic [7:0] O_RST = 8'b0111_0110;
  localparam logic [7:0] O_RUN = 8'b1101_1110;
  localparam logic [7:0] O_RAW = 8'b0001_0110;
  localparam logic [7:0] O_RDR = 8'b1111_0110;
  localparam logic [7:0] O_IMS = 8'b0111_1110;
  localparam logic [7:0] O_FRZ = 8'b0000_0000;
  localparam logic [7:0] O_DRN = 8'b0111_0110;
  localparam logic [7:0] O_HLT = 8'b0111_0111;
  localparam logic [7:0] O_HFZ = 8'b0000_0001;

  logic       clk;
  logic       rst;
  logic [2:0] Rs_id, Rt_id, WrReg_id;
  logic       RsUsed_id, RtUsed_id, RegWrite_id, MemtoReg_id, Halt_id;
  logic       BrTaken_ex, IMemStall, DMemStall;
  logic [2:0] pcen, ifiden, ifidfl, idexen, idexps, exmemen, memwben, halted;

  int checks = 0;
  int errors = 0;

  // Instance 0: FWD=1,WB_BYPASS=1; 1: FWD=0,WB_BYPASS=0; 2: FWD=0,WB_BYPASS=1
  for (genvar g = 0; g < 3; g++) begin : g_dut
    hazard_ctrl #(.FWD(g == 0), .WB_BYPASS(g != 1), .DRAIN_CYC(3)) u_dut (
      .clk(clk), .rst(rst),
      .Rs_id(Rs_id), .RsUsed_id(RsUsed_id), .Rt_id(Rt_id), .RtUsed_id(RtUsed_id),
      .WrReg_id(WrReg_id), .RegWrite_id(RegWrite_id), .MemtoReg_id(MemtoReg_id),
      .Halt_id(Halt_id), .BrTaken_ex(BrTaken_ex), .IMemStall(IMemStall),
      .DMemStall(DMemStall),
      .PCEn(pcen[g]), .IfidEn(ifiden[g]), .IfidFlush(ifidfl[g]), .IdexEn(idexen[g]),
      .IdexPass(idexps[g]), .ExmemEn(exmemen[g]), .MemwbEn(memwben[g]),
      .Halted(halted[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: in-flight instructions by age (0=EX,1=MEM,2=WB) per config.
  typedef struct packed { bit v; bit [2:0] r; bit ld; } inst_t;
  inst_t m_pipe [3][3];
  bit    m_live [3];
  bit    m_halt_acc [3];
  int    m_seen [3];

  function automatic logic [7:0] dut_out(int k);
    return {pcen[k], ifiden[k], ifidfl[k], idexen[k], idexps[k], exmemen[k], memwben[k], halted[k]};
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b", name, got, exp);
    end
  endtask

  task automatic model_step(input int k, output logic [7:0] exp);
    bit fwd = (k == 0);
    bit wbb = (k != 1);
    bit raw = 1'b0;
    bit is_halted, draining, pass;
    for (int s = 0; s < 3; s++) begin
      inst_t p = m_pipe[k][s];
      bit reads = (RsUsed_id && Rs_id == p.r) || (RtUsed_id && Rt_id == p.r);
      if (p.v && reads) begin
        if (fwd) raw |= (s == 0) && p.ld;
        else     raw |= (s < 2) || !wbb;
      end
    end
    is_halted = m_halt_acc[k] && (m_seen[k] >= 3);
    draining  = m_halt_acc[k] && !is_halted;
    if (rst)                         exp = O_RST;
    else if (DMemStall)              exp = is_halted ? O_HFZ : O_FRZ;
    else if (is_halted)              exp = O_HLT;
    else if (draining)               exp = O_DRN;
    else if (BrTaken_ex && m_live[k]) exp = O_RDR;
    else if (raw)                    exp = O_RAW;
    else if (IMemStall)              exp = O_IMS;
    else                             exp = O_RUN;
    if (rst) begin
      for (int s = 0; s < 3; s++) m_pipe[k][s] = '0;
      m_live[k] = 1'b0; m_halt_acc[k] = 1'b0; m_seen[k] = 0;
    end else if (!DMemStall) begin
      pass = exp[3];
      m_pipe[k][2] = m_pipe[k][1];
      m_pipe[k][1] = m_pipe[k][0];
      m_pipe[k][0] = '{v: pass && RegWrite_id, r: WrReg_id, ld: MemtoReg_id};
      m_live[k] = pass;
      if (draining) m_seen[k]++;
      if (!m_halt_acc[k] && pass && Halt_id) begin
        m_halt_acc[k] = 1'b1;
        m_seen[k] = 0;
      end
    end
  endtask

  task automatic tick(input string tag, input logic [23:0] want, input logic [2:0] mask);
    logic [7:0] e;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      model_step(k, e);
      check($sformatf("%s/model%0d", tag, k), dut_out(k), e);
      if (mask[k]) check($sformatf("%s/dir%0d", tag, k), dut_out(k), want[8*k +: 8]);
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string      name;
    logic       rst;
    logic [2:0] rs;  logic rsu;
    logic [2:0] rt;  logic rtu;
    logic [2:0] wr;  logic rw; logic ld;
    logic       halt, br, ims, dms;
    logic [7:0] exp;
  } vec_t;

  vec_t vtab[$];

  function automatic vec_t mk(string n, logic r, logic [2:0] rs, logic rsu, logic [2:0] rt,
                              logic rtu, logic [2:0] wr, logic rw, logic ld, logic h,
                              logic b, logic im, logic dm, logic [7:0] e);
    vec_t v;
    v.name = n; v.rst = r; v.rs = rs; v.rsu = rsu; v.rt = rt; v.rtu = rtu;
    v.wr = wr; v.rw = rw; v.ld = ld; v.halt = h; v.br = b; v.ims = im; v.dms = dm; v.exp = e;
    return v;
  endfunction

  task automatic drive(input logic r, input logic [2:0] rs, input logic rsu, input logic [2:0] rt,
                       input logic rtu, input logic [2:0] wr, input logic rw, input logic ld,
                       input logic h, input logic b, input logic im, input logic dm);
    rst = r; Rs_id = rs; RsUsed_id = rsu; Rt_id = rt; RtUsed_id = rtu;
    WrReg_id = wr; RegWrite_id = rw; MemtoReg_id = ld; Halt_id = h;
    BrTaken_ex = b; IMemStall = im; DMemStall = dm;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      for (int s = 0; s < 3; s++) m_pipe[k][s] = '0;
      m_live[k] = 1'b0; m_halt_acc[k] = 1'b0; m_seen[k] = 0;
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    //                 name            rst rs rsu rt rtu wr rw ld  h  b im dm  exp (FWD=1 instance)
    vtab.push_back(mk("reset",          1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RST));
    vtab.push_back(mk("idle",           0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN));
    vtab.push_back(mk("ld_r3",          0, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0, O_RUN));
    vtab.push_back(mk("use_r3",         0, 2, 1, 3, 1, 1, 1, 0, 0, 0, 0, 0, O_RAW));
    vtab.push_back(mk("use_r3_go",      0, 2, 1, 3, 1, 1, 1, 0, 0, 0, 0, 0, O_RUN));
    vtab.push_back(mk("ld_r3b",         0, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0, O_RUN));
    vtab.push_back(mk("nouse_r3",       0, 3, 0, 2, 1, 7, 1, 0, 0, 0, 0, 0, O_RUN));
    vtab.push_back(mk("br_live",        0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_RDR));
    vtab.push_back(mk("br_bubble",      0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_RUN));
    vtab.push_back(mk("ld_r5",          0, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, O_RUN));
    vtab.push_back(mk("dms1",           0, 5, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, O_FRZ));
    vtab.push_back(mk("dms2",           0, 5, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, O_FRZ));
    vtab.push_back(mk("dms3",           0, 5, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, O_FRZ));
    vtab.push_back(mk("dms4",           0, 5, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, O_FRZ));
    vtab.push_back(mk("dms_redir",      0, 5, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_RDR));
    vtab.push_back(mk("after_redir",    0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN));
    vtab.push_back(mk("imem",           0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_IMS));
    vtab.push_back(mk("ld_r6",          0, 0, 0, 0, 0, 6, 1, 1, 0, 0, 0, 0, O_RUN));
    vtab.push_back(mk("raw_over_imem",  0, 0, 0, 6, 1, 0, 0, 0, 0, 0, 1, 0, O_RAW));
    vtab.push_back(mk("idle2",          0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN));
    vtab.push_back(mk("halt_in",        0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, O_RUN));
    vtab.push_back(mk("drain1",         0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_DRN));
    vtab.push_back(mk("drain_dms",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, O_FRZ));
    vtab.push_back(mk("drain2",         0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_DRN));
    vtab.push_back(mk("drain3",         0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_DRN));
    vtab.push_back(mk("halted",         0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_HLT));
    vtab.push_back(mk("halted_dms",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, O_HFZ));
    vtab.push_back(mk("halted_hold",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_HLT));
    vtab.push_back(mk("halt_rst",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RST));
    vtab.push_back(mk("post_rst",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN));
    vtab.push_back(mk("rst_dms",        1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, O_RST));
    vtab.push_back(mk("after_rst_dms",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN));
    vtab.push_back(mk("ld_r2",          0, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0, 0, O_RUN));
    vtab.push_back(mk("use_r2",         0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RAW));
    vtab.push_back(mk("rst_raw",        1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RST));
    vtab.push_back(mk("use_r2_clr",     0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN));
    vtab.push_back(mk("halt_br",        0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, O_RDR));
    vtab.push_back(mk("no_drain",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN));
    vtab.push_back(mk("no_drain2",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN));

    foreach (vtab[i]) begin
      drive(vtab[i].rst, vtab[i].rs, vtab[i].rsu, vtab[i].rt, vtab[i].rtu, vtab[i].wr,
            vtab[i].rw, vtab[i].ld, vtab[i].halt, vtab[i].br, vtab[i].ims, vtab[i].dms);
      tick(vtab[i].name, {16'h0, vtab[i].exp}, 3'b001);
    end

    // Non-load producer without forwarding: stall length depends on WB bypass.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick("nf_reset", {O_RST, O_RST, O_RST}, 3'b111);
    drive(0, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 0);
    tick("nf_add_r4", {O_RUN, O_RUN, O_RUN}, 3'b111);
    drive(0, 4, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    tick("nf_use1", {O_RAW, O_RAW, O_RUN}, 3'b111);
    tick("nf_use2", {O_RAW, O_RAW, O_RUN}, 3'b110);
    tick("nf_use3", {O_RUN, O_RAW, O_RUN}, 3'b110);
    tick("nf_use4", {O_RUN, O_RUN, O_RUN}, 3'b110);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 39) == 0,
            3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
      tick("rand", 24'h0, 3'b000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
